// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg: shared encodings for the memory/writeback stage.
package mem_wb_stage_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;
  localparam int PC_INC = 4;
endpackage

// File: rtl/bufRegister.sv
// bufRegister: write-enabled pipeline buffer register, async active-low reset.
module bufRegister #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wrtEn,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) dout <= '0;
    else if (wrtEn) dout <= din;
endmodule

// File: rtl/mem_access_fsm.sv
// mem_access_fsm: data-memory req/ack sequencer with address/data capture.
// Optional abort of stuck accesses under MEM_TIMEOUT_EN.
module mem_access_fsm
  import mem_wb_stage_pkg::*;
#(
  parameter int BIT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_op_i,
  input  logic                 we_i,
  input  logic [BIT_WIDTH-1:0] addr_i,
  input  logic [BIT_WIDTH-1:0] wdata_i,
  input  logic [BIT_WIDTH-1:0] rdata_i,
  input  logic                 ack_i,
  output logic                 req_o,
  output logic                 we_o,
  output logic [BIT_WIDTH-1:0] addr_o,
  output logic [BIT_WIDTH-1:0] wdata_o,
  output logic [BIT_WIDTH-1:0] rd_data_o,
  output logic                 stall_o,
  output logic                 err_o
);
  state_e                 state_q, state_d;
  logic                   we_q, start, in_access, done_ok, timeout;
  logic [BIT_WIDTH-1:0]   addr_q, wdata_q, rd_q;
  assign start     = (state_q == IDLE) && mem_op_i;
  assign in_access = (state_q == ACCESS);
  assign done_ok   = in_access && ack_i;
`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  logic          err_q;
  // an ack arriving on the final cycle still completes normally
  assign timeout = in_access && !ack_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (start) cnt_q <= '0;
      else if (in_access && !ack_i) cnt_q <= cnt_q + 1'b1;
      if (timeout) err_q <= 1'b1;
    end
  assign err_o = err_q;
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    state_d = (state_q == IDLE)   ? (mem_op_i ? ACCESS : IDLE) :
              (state_q == ACCESS) ? ((done_ok || timeout) ? RESP : ACCESS) : IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        we_q    <= we_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
      if (done_ok) rd_q <= rdata_i;
      else if (timeout) rd_q <= '0;
    end
  // reset gating keeps stall low while reset is held, even with a memory op presented
  assign stall_o   = reset && (start || in_access);
  assign req_o     = in_access;
  assign we_o      = we_q && in_access;
  assign addr_o    = addr_q;
  assign wdata_o   = wdata_q;
  assign rd_data_o = rd_q;
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory access sequencing and registered writeback select.
// Define MEM_TIMEOUT_EN to abort accesses after TIMEOUT_CYCLES and flag memErr.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int BIT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 regWrEn,
  input  logic [3:0]           regWrAddr,
  input  logic [BIT_WIDTH-1:0] dataIn,
  input  logic                 memWrEn,
  input  logic                 isLoad,
  input  logic                 isStore,
  input  logic [1:0]           mulSel,
  input  logic [BIT_WIDTH-1:0] aluOut,
  input  logic [BIT_WIDTH-1:0] PC,
  output logic                 memReq,
  output logic                 memWe,
  output logic [BIT_WIDTH-1:0] memAddr,
  output logic [BIT_WIDTH-1:0] memWrData,
  input  logic [BIT_WIDTH-1:0] memRdData,
  input  logic                 memAck,
  output logic                 stall,
  output logic                 wbEn,
  output logic [3:0]           wbAddr,
  output logic [BIT_WIDTH-1:0] wbData,
  output logic                 memErr
);
  logic                   store_op, mem_op;
  logic [BIT_WIDTH-1:0]   rd_data, sel_data;
  logic [BIT_WIDTH+4:0]   wb_d, wb_q;
  assign store_op = isStore & memWrEn;
  assign mem_op   = isLoad | store_op;
  mem_access_fsm #(
    .BIT_WIDTH     (BIT_WIDTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_fsm (
    .clk      (clk),
    .reset    (reset),
    .mem_op_i (mem_op),
    .we_i     (store_op),
    .addr_i   (aluOut),
    .wdata_i  (dataIn),
    .rdata_i  (memRdData),
    .ack_i    (memAck),
    .req_o    (memReq),
    .we_o     (memWe),
    .addr_o   (memAddr),
    .wdata_o  (memWrData),
    .rd_data_o(rd_data),
    .stall_o  (stall),
    .err_o    (memErr)
  );
  assign sel_data = (mulSel == WB_SEL_MEM) ? rd_data :
                    (mulSel == WB_SEL_PC4) ? PC + BIT_WIDTH'(PC_INC) : aluOut;
  // stall inserts a bubble while recirculating the last address/data
  assign wb_d = stall ? {1'b0, wbAddr, wbData} : {regWrEn, regWrAddr, sel_data};
  bufRegister #(.WIDTH(BIT_WIDTH + 5)) u_wb (
    .clk  (clk),
    .reset(reset),
    .wrtEn(1'b1),
    .din  (wb_d),
    .dout (wb_q)
  );
  assign {wbEn, wbAddr, wbData} = wb_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed test with writeback scoreboard.
module tb_mem_wb_stage;
  logic        clk = 1'b0, reset = 1'b0;
  logic        regWrEn, memWrEn, isLoad, isStore, memAck;
  logic [3:0]  regWrAddr, wbAddr;
  logic [1:0]  mulSel;
  logic [31:0] dataIn, aluOut, PC, memRdData, memAddr, memWrData, wbData;
  logic        memReq, memWe, stall, wbEn, memErr;
  int          checks = 0, errors = 0;
  logic [35:0] sb_q[$];
  logic [31:0] last_rd;

  mem_wb_stage dut (
    .clk(clk), .reset(reset), .regWrEn(regWrEn), .regWrAddr(regWrAddr), .dataIn(dataIn),
    .memWrEn(memWrEn), .isLoad(isLoad), .isStore(isStore), .mulSel(mulSel), .aluOut(aluOut),
    .PC(PC), .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWrData(memWrData),
    .memRdData(memRdData), .memAck(memAck), .stall(stall), .wbEn(wbEn), .wbAddr(wbAddr),
    .wbData(wbData), .memErr(memErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wbEn === 1'b1) begin
      if (sb_q.size() == 0) chk("wb_unexpected", {wbAddr, wbData}, 36'h0);
      else chk("wb_data", {wbAddr, wbData}, sb_q.pop_front());
    end
  end

  task automatic idle_in();
    regWrEn = 0; regWrAddr = 0; dataIn = 0; memWrEn = 0; isLoad = 0; isStore = 0;
    mulSel = 0; aluOut = 0; PC = 0; memAck = 0; memRdData = 0;
  endtask

  task automatic mem_txn(input int wait_cycles, input logic [31:0] addr, input logic we,
                         input logic [31:0] wdata, input logic [31:0] rdata, input string tag);
    #1 chk({tag, "_stall_idle"}, 36'(stall), 36'd1);
    for (int i = 1; i <= wait_cycles; i++) begin
      @(negedge clk);
      chk({tag, "_req"}, {34'(memReq), memWe, stall}, {34'd1, we, 1'b1});
      chk({tag, "_addr"}, 36'(memAddr), 36'(addr));
      if (we) chk({tag, "_wdata"}, 36'(memWrData), 36'(wdata));
      if (i == wait_cycles) begin memAck = 1; memRdData = rdata; last_rd = rdata; end
    end
    @(negedge clk);
    memAck = 0; memRdData = 32'hBAD0BAD0;
    chk({tag, "_resp"}, {34'(memReq), stall, wbEn}, 36'd0);
  endtask

  initial begin
    idle_in();
    last_rd = 0;
    repeat (2) @(negedge clk);
    chk("reset_ctl", {31'd0, memReq, memWe, stall, wbEn, memErr}, 36'd0);
    chk("reset_wb", {wbAddr, wbData}, 36'd0);
    chk("reset_mem", 36'(memAddr | memWrData), 36'd0);
    reset = 1;
    @(negedge clk);
    regWrEn = 1; regWrAddr = 5; aluOut = 32'h1234; mulSel = 0;
    #1 chk("alu_stall", 36'(stall), 36'd0);
    sb_q.push_back({4'd5, 32'h1234});
    @(negedge clk);
    chk("alu_wben", 36'(wbEn), 36'd1);
    idle_in();
    @(negedge clk);
    regWrEn = 1; regWrAddr = 3; isLoad = 1; aluOut = 32'h100; mulSel = 1;
    sb_q.push_back({4'd3, 32'hCAFEF00D});
    mem_txn(3, 32'h100, 1'b0, 32'h0, 32'hCAFEF00D, "load");
    @(negedge clk);
    chk("load_wben", 36'(wbEn), 36'd1);
    idle_in();
    @(negedge clk);
    chk("load_once", 36'(wbEn), 36'd0);
    isStore = 1; memWrEn = 1; aluOut = 32'h40; dataIn = 32'h55;
    mem_txn(1, 32'h40, 1'b1, 32'h55, 32'h0000_0077, "store");
    @(negedge clk);
    idle_in();
    #1 chk("store_noreq1", {34'(memReq), stall, wbEn}, 36'd0);
    @(negedge clk);
    chk("store_noreq2", {35'(memReq), wbEn}, 36'd0);
    isStore = 1; memWrEn = 0; regWrEn = 1; regWrAddr = 9; aluOut = 32'h99;
    #1 chk("store_noop_stall", 36'(stall), 36'd0);
    sb_q.push_back({4'd9, 32'h99});
    @(negedge clk);
    idle_in();
    isLoad = 1; isStore = 1; memWrEn = 1; regWrEn = 1; regWrAddr = 7; aluOut = 32'h80; dataIn = 32'hA1;
    sb_q.push_back({4'd7, 32'h80});
    mem_txn(2, 32'h80, 1'b1, 32'hA1, 32'h1357_9BDF, "ldst");
    @(negedge clk);
    idle_in();
    regWrEn = 1; regWrAddr = 1; PC = 32'hFFFF_FFFC; mulSel = 2;
    sb_q.push_back({4'd1, 32'h0});
    @(negedge clk);
    regWrAddr = 2; PC = 32'h0000_1000;
    sb_q.push_back({4'd2, 32'h1004});
    @(negedge clk);
    regWrAddr = 4; mulSel = 3; aluOut = 32'hDEAD_BEEF;
    sb_q.push_back({4'd4, 32'hDEAD_BEEF});
    @(negedge clk);
    regWrAddr = 6; mulSel = 1;
    sb_q.push_back({4'd6, last_rd});
    @(negedge clk);
    idle_in();
`ifdef MEM_TIMEOUT_EN
    regWrEn = 1; regWrAddr = 2; isLoad = 1; aluOut = 32'h200; mulSel = 1;
    sb_q.push_back({4'd2, 32'h0});
    #1 chk("to_stall", 36'(stall), 36'd1);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      chk("to_req", 36'(memReq), 36'd1);
    end
    @(negedge clk);
    chk("to_resp", {34'(memReq), memErr, stall}, {34'd0, 1'b1, 1'b0});
    @(negedge clk);
    idle_in();
    @(negedge clk);
    chk("to_sticky", 36'(memErr), 36'd1);
    regWrEn = 1; regWrAddr = 4; isLoad = 1; aluOut = 32'h300; mulSel = 1;
    sb_q.push_back({4'd4, 32'hA5A5_A5A5});
    mem_txn(16, 32'h300, 1'b0, 32'h0, 32'hA5A5_A5A5, "to_ack16");
    @(negedge clk);
    idle_in();
`endif
    @(negedge clk);
    regWrEn = 1; regWrAddr = 8; isLoad = 1; aluOut = 32'h500; mulSel = 1;
    @(negedge clk);
    chk("rst_pre_req", 36'(memReq), 36'd1);
    reset = 0;
    #1 chk("rst_mid", {33'd0, memReq, stall, wbEn}, 36'd0);
    @(negedge clk);
    idle_in();
    chk("rst_err", 36'(memErr), 36'd0);
    reset = 1;
    @(negedge clk);
    chk("rst_idle", {34'(memReq), stall, wbEn}, 36'd0);
    @(negedge clk);
    chk("sb_empty", 36'(sb_q.size()), 36'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
